// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution datapath: default widths, result-width
// helper and the line-buffer controller state encoding.
package cnn_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int K_DEF      = 3;

  // Full-precision width of a K*K sum of DATA_W x DATA_W signed products
  function automatic int acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_CAPT = 2'd2,
    S_OUT  = 2'd3
  } conv_state_e;

endpackage

// File: rtl/lb_conv_ctrl_if.sv
// Line-buffer read port and result stream of the convolution controller.
interface lb_conv_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int AW     = 5
);

  localparam int ACC_W = cnn_pkg::acc_w(DATA_W, K);

  // Read port: data for lb_rd_addr appears on lb_rd_data the cycle after lb_rd_en.
  logic                    lb_rd_en;
  logic [AW-1:0]           lb_rd_addr;
  logic [K*DATA_W-1:0]     lb_rd_data;

  // Result stream: out_valid rises with a new out_data and both hold unchanged
  // until out_ready is high; a transfer happens on every edge where both are 1.
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output lb_rd_en, lb_rd_addr, out_data, out_valid,
    input  lb_rd_data, out_ready
  );

  modport slave (
    input  lb_rd_en, lb_rd_addr, out_data, out_valid,
    output lb_rd_data, out_ready
  );

endinterface

// File: rtl/lb_conv_mac.sv
// Combinational KxK signed dot product at full precision; shared with the
// pooling path, so it carries no state of its own.
module lb_conv_mac
  import cnn_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int K      = K_DEF,
  localparam int ACC_W  = acc_w(DATA_W, K)
) (
  input  logic [K*K*DATA_W-1:0] window,
  input  logic [K*K*DATA_W-1:0] weights,
  output logic signed [ACC_W-1:0] sum
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] prod [K*K];

  for (genvar i = 0; i < K * K; i++) begin : g_prod
    logic signed [DATA_W-1:0] pix;
    logic signed [DATA_W-1:0] wgt;
    assign pix     = window[i*DATA_W +: DATA_W];
    assign wgt     = weights[i*DATA_W +: DATA_W];
    assign prod[i] = PW'(pix) * PW'(wgt);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < K * K; i++) begin
      sum = sum + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/lb_conv_ctrl.sv
// Line-buffer convolution controller: walks K rotating line buffers column by
// column, keeps a KxK window and streams one signed result per window position.
module lb_conv_ctrl
  import cnn_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int K      = K_DEF,
  parameter  int IMG_W  = 28,
  parameter  int IMG_H  = 28,
  parameter  int AW     = $clog2(IMG_W),
  localparam int ACC_W  = acc_w(DATA_W, K),
  localparam int RW     = (K > 1) ? $clog2(K) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_valid,
  input  logic [K*K*DATA_W-1:0] weights,
  lb_conv_ctrl_if.master        bus,
  output logic [RW-1:0]         rot_idx,
  output logic                  busy,
  output logic                  row_done,
  output logic                  frame_done,
  output logic                  err_overflow,
  output conv_state_e           dbg_state
);

  localparam int ROWS = IMG_H - K + 1;
  localparam int CW   = $clog2(IMG_H + 1);

  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
  localparam logic [AW-1:0] COL_FILL = AW'(K - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROWS - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(K - 1);

  conv_state_e             state;
  logic [AW-1:0]           col;
  logic [CW-1:0]           row_cnt;
  logic                    pending;
  logic                    row_end;
  logic [DATA_W-1:0]       win     [K][K];
  logic [DATA_W-1:0]       win_nxt [K][K];
  logic [K*K*DATA_W-1:0]   win_flat;
  logic signed [ACC_W-1:0] mac_sum;

  function automatic int buf_sel(input logic [RW-1:0] rot, input int r);
    return (int'(rot) + r) % K;
  endfunction

  // Window after this cycle's capture; the MAC sees it so the result can be
  // registered on the same edge that loads the last column.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][K-1] = bus.lb_rd_data[buf_sel(rot_idx, r)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[(r*K+c)*DATA_W +: DATA_W] = win_nxt[r][c];
      end
    end
  end

  lb_conv_mac #(
    .DATA_W(DATA_W),
    .K     (K)
  ) u_mac (
    .window (win_flat),
    .weights(weights),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (state == S_CAPT) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= win_nxt[r][c];
        end
      end
    end
  end

  assign row_end   = (state == S_OUT) && bus.out_ready && (col == COL_LAST);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      col            <= '0;
      row_cnt        <= '0;
      rot_idx        <= '0;
      pending        <= 1'b0;
      err_overflow   <= 1'b0;
      row_done       <= 1'b0;
      frame_done     <= 1'b0;
      bus.lb_rd_en   <= 1'b0;
      bus.lb_rd_addr <= '0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;

      // One request may queue behind the running row; a second one is lost.
      if (row_valid && (state != S_IDLE) && !row_end) begin
        if (pending) err_overflow <= 1'b1;
        else         pending      <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (row_valid || pending) begin
            pending        <= 1'b0;
            col            <= '0;
            bus.lb_rd_en   <= 1'b1;
            bus.lb_rd_addr <= '0;
            state          <= S_READ;
          end
        end

        S_READ: begin
          bus.lb_rd_en   <= 1'b0;
          bus.lb_rd_addr <= '0;
          state          <= S_CAPT;
        end

        S_CAPT: begin
          if (col < COL_FILL) begin
            col            <= col + 1'b1;
            bus.lb_rd_en   <= 1'b1;
            bus.lb_rd_addr <= col + 1'b1;
            state          <= S_READ;
          end else begin
            bus.out_data  <= mac_sum;
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end
        end

        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (col == COL_LAST) begin
              row_done <= 1'b1;
              if (row_cnt == ROW_LAST) begin
                frame_done <= 1'b1;
                row_cnt    <= '0;
                rot_idx    <= '0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                rot_idx <= (rot_idx == ROT_LAST) ? '0 : rot_idx + 1'b1;
              end
              // A queued or same-cycle request starts the next row without an IDLE gap
              if (pending || row_valid) begin
                pending        <= pending && row_valid;
                col            <= '0;
                bus.lb_rd_en   <= 1'b1;
                bus.lb_rd_addr <= '0;
                state          <= S_READ;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              col            <= col + 1'b1;
              bus.lb_rd_en   <= 1'b1;
              bus.lb_rd_addr <= col + 1'b1;
              state          <= S_READ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lb_conv_ctrl.sv
// Directed bench for lb_conv_ctrl with K=3, IMG_W=5, IMG_H=4: a table of full
// rows plus hand-written backpressure, queued-request and reset sequences.
module tb_lb_conv_ctrl;
  import cnn_pkg::*;

  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int AW     = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  row_valid;
  logic [K*K*DATA_W-1:0] weights;
  logic [1:0]            rot_idx;
  logic                  busy;
  logic                  row_done;
  logic                  frame_done;
  logic                  err_overflow;
  conv_state_e           dbg_state;

  lb_conv_ctrl_if #(.DATA_W(DATA_W), .K(K), .AW(AW)) bus ();

  lb_conv_ctrl #(
    .DATA_W(DATA_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_valid   (row_valid),
    .weights     (weights),
    .bus         (bus),
    .rot_idx     (rot_idx),
    .busy        (busy),
    .row_done    (row_done),
    .frame_done  (frame_done),
    .err_overflow(err_overflow),
    .dbg_state   (dbg_state)
  );

  // line-buffer model: one-cycle read latency
  logic [DATA_W-1:0] mem [K][8];
  always @(posedge clk) begin
    if (bus.lb_rd_en) begin
      for (int p = 0; p < K; p++) bus.lb_rd_data[p*DATA_W +: DATA_W] <= mem[p][bus.lb_rd_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_weights(input int mode);
    weights = '0;
    case (mode)
      0: weights[4*DATA_W +: DATA_W] = 8'd1;
      1: weights[1*DATA_W +: DATA_W] = 8'd1;
      2: for (int i = 0; i < K * K; i++) weights[i*DATA_W +: DATA_W] = 8'd1;
      3: for (int i = 0; i < K * K; i++) weights[i*DATA_W +: DATA_W] = 8'h80;
      default: begin
        weights[8*DATA_W +: DATA_W] = 8'd2;
        weights[0 +: DATA_W]        = 8'hFF;
      end
    endcase
  endtask

  task automatic set_pix(input int mode, input int val);
    for (int p = 0; p < K; p++) begin
      for (int c = 0; c < 8; c++) begin
        mem[p][c] = (mode == 0) ? 8'(10 * p + c) : 8'(val);
      end
    end
  endtask

  task automatic pulse_rv();
    @(negedge clk);
    row_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; n = cycles waited.
  task automatic get_out(output longint d, output int n, output bit ok);
    d  = 0;
    n  = 0;
    ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        d  = longint'(bus.out_data);
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_out(input string name, input longint exp);
    longint d;
    int     n;
    bit     ok;
    get_out(d, n, ok);
    chk({name, "_seen"}, longint'(ok), 1);
    chk(name, d, exp);
  endtask

  task automatic row_end_chk(input string name, input int fd, input int rot);
    @(negedge clk);
    chk({name, "_row_done"}, longint'(row_done), 1);
    chk({name, "_frame_done"}, longint'(frame_done), fd);
    chk({name, "_rot_idx"}, longint'(rot_idx), rot);
  endtask

  typedef struct {
    int wmode;
    int pmode;
    int pval;
    int e0;
    int e1;
    int e2;
  } vec_t;

  vec_t vecs [6];

  function automatic int exp_of(input vec_t x, input int o);
    return (o == 0) ? x.e0 : (o == 1) ? x.e1 : x.e2;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    longint d;
    int     n;
    bit     ok;

    // row order alternates rot_idx 0,1 (two output rows per frame)
    vecs[0] = '{0, 0, 0,    11,     12,     13};     // identity
    vecs[1] = '{1, 0, 0,    11,     12,     13};     // top-middle, rot 1 -> buffer 1
    vecs[2] = '{2, 1, 127,  1143,   1143,   1143};
    vecs[3] = '{3, 1, -128, 147456, 147456, 147456};
    vecs[4] = '{4, 0, 0,    44,     45,     46};     // 2*buf2[c+2] - buf0[c]
    vecs[5] = '{4, 0, 0,    -6,     -5,     -4};     // 2*buf0[c+2] - buf1[c]

    row_valid     = 1'b0;
    bus.out_ready = 1'b1;
    set_weights(0);
    set_pix(0, 0);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_rd_en", longint'(bus.lb_rd_en), 0);
    chk("rst_rot_idx", longint'(rot_idx), 0);
    chk("rst_err", longint'(err_overflow), 0);
    chk("rst_state", longint'(dbg_state), longint'(S_IDLE));
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      set_weights(vecs[v].wmode);
      set_pix(vecs[v].pmode, vecs[v].pval);
      chk($sformatf("vec%0d_rot_before", v), longint'(rot_idx), v % 2);
      pulse_rv();
      chk($sformatf("vec%0d_rd_start", v), longint'({bus.lb_rd_en, bus.lb_rd_addr}), 8);
      for (int o = 0; o < 3; o++) begin
        get_out(d, n, ok);
        chk($sformatf("vec%0d_out%0d_seen", v, o), longint'(ok), 1);
        chk($sformatf("vec%0d_out%0d", v, o), d, exp_of(vecs[v], o));
        chk($sformatf("vec%0d_out%0d_latency", v, o), n, (o == 0) ? 2 * K : 3);
      end
      row_end_chk($sformatf("vec%0d", v), v % 2, (v % 2 == 0) ? 1 : 0);
      chk($sformatf("vec%0d_busy_after", v), longint'(busy), 0);
    end
    chk("table_err", longint'(err_overflow), 0);

    // backpressure on the first result
    set_weights(0);
    set_pix(0, 0);
    bus.out_ready = 1'b0;
    pulse_rv();
    expect_out("bp_first", 11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), longint'(bus.out_valid), 1);
      chk($sformatf("bp_hold%0d_data", i), longint'(bus.out_data), 11);
      chk($sformatf("bp_hold%0d_rd_en", i), longint'(bus.lb_rd_en), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", longint'(bus.out_valid), 0);
    chk("bp_release_rd_en", longint'(bus.lb_rd_en), 1);
    chk("bp_release_addr", longint'(bus.lb_rd_addr), 3);
    expect_out("bp_out1", 12);
    expect_out("bp_out2", 13);
    row_end_chk("bp", 0, 1);

    // queued request, then overflow
    pulse_rv();
    pulse_rv();
    chk("pend_err_clear", longint'(err_overflow), 0);
    chk("pend_busy", longint'(busy), 1);
    expect_out("pend_r0_out0", 21);
    expect_out("pend_r0_out1", 22);
    expect_out("pend_r0_out2", 23);
    row_end_chk("pend_r0", 1, 0);
    chk("pend_r1_start", longint'({bus.lb_rd_en, bus.lb_rd_addr}), 8);
    pulse_rv();
    pulse_rv();
    chk("ovf_err_set", longint'(err_overflow), 1);
    expect_out("pend_r1_out0", 11);
    expect_out("pend_r1_out1", 12);
    expect_out("pend_r1_out2", 13);
    row_end_chk("pend_r1", 0, 1);
    chk("pend_r2_start", longint'(bus.lb_rd_en), 1);
    expect_out("pend_r2_out0", 21);
    expect_out("pend_r2_out1", 22);
    expect_out("pend_r2_out2", 23);
    row_end_chk("pend_r2", 1, 0);
    chk("ovf_err_sticky", longint'(err_overflow), 1);
    chk("pend_idle", longint'(busy), 0);

    // reset in the middle of the second row of a frame
    pulse_rv();
    expect_out("rr_r0_out0", 11);
    expect_out("rr_r0_out1", 12);
    expect_out("rr_r0_out2", 13);
    row_end_chk("rr_r0", 0, 1);
    pulse_rv();
    expect_out("rr_r1_out0", 21);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_out_data", longint'(bus.out_data), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_rd_en", longint'(bus.lb_rd_en), 0);
    chk("mid_rst_addr", longint'(bus.lb_rd_addr), 0);
    chk("mid_rst_rot_idx", longint'(rot_idx), 0);
    chk("mid_rst_err", longint'(err_overflow), 0);
    chk("mid_rst_state", longint'(dbg_state), longint'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;
    pulse_rv();
    chk("restart_rd", longint'({bus.lb_rd_en, bus.lb_rd_addr}), 8);
    get_out(d, n, ok);
    chk("restart_seen", longint'(ok), 1);
    chk("restart_out0", d, 11);
    chk("restart_latency", n, 2 * K);
    expect_out("restart_out1", 12);
    expect_out("restart_out2", 13);
    row_end_chk("restart", 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
